// File: rtl/kamus_mem.sv
// kamus_mem: memory-access stage behind kamus_EX.
// It issues one L1D load or store at a time over a req/gnt/rvalid handshake.
// It formats load data and registers a one-cycle result bundle for writeback.
// Misaligned accesses never reach the bus.
// An access still pending after REQ_TIMEOUT cycles ends as a bus error.
module kamus_mem #(
  parameter int REQ_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [5:0]  operation_i,
  input  logic [31:0] ex_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        regfile_wr_en_i,
  input  logic [1:0]  wb_mux_sel_i,
  input  logic        l1d_wr_en_i,
  input  logic [31:0] next_pc_i,
  output logic        l1d_req_o,
  input  logic        l1d_gnt_i,
  output logic        l1d_we_o,
  output logic [31:0] l1d_addr_o,
  output logic [3:0]  l1d_be_o,
  output logic [31:0] l1d_wdata_o,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [31:0] mem_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        regfile_wr_en_o,
  output logic [1:0]  wb_mux_sel_o,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic [31:0] fault_addr_o
);

  // operation_e encodings of the memory ops; every other code is a non-memory op
  localparam logic [5:0] OP_LB  = 6'h10;
  localparam logic [5:0] OP_LH  = 6'h11;
  localparam logic [5:0] OP_LW  = 6'h12;
  localparam logic [5:0] OP_LBU = 6'h13;
  localparam logic [5:0] OP_LHU = 6'h14;
  localparam logic [5:0] OP_SB  = 6'h18;
  localparam logic [5:0] OP_SH  = 6'h19;
  localparam logic [5:0] OP_SW  = 6'h1A;

  // counter is wide enough to hold REQ_TIMEOUT itself, so it cannot wrap past the limit
  localparam int CNT_W = $clog2(REQ_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       op_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       be_reg;
  logic             we_reg;
  logic [4:0]       rd_reg;
  logic             rf_we_reg;
  logic [1:0]       sel_reg;
  logic [31:0]      pc_reg;

  logic        in_load, in_store, in_byte, in_half, in_mem, in_mis;
  logic        accept, acc_go, acc_mis;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        fin_store, fin_load, fin_tmo, timeout_hit;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_fmt;

  assign ready_o     = (state_reg == IDLE);
  assign l1d_req_o   = (state_reg == REQ);
  assign l1d_we_o    = we_reg;
  assign l1d_addr_o  = {addr_reg[31:2], 2'b00};
  assign l1d_be_o    = be_reg;
  assign l1d_wdata_o = wdata_reg;

  // decode the incoming op: direction, access size, alignment, lanes
  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_byte  = 1'b0;
    in_half  = 1'b0;
    case (operation_i)
      OP_LB, OP_LBU: begin in_load = 1'b1;  in_byte = 1'b1; end
      OP_LH, OP_LHU: begin in_load = 1'b1;  in_half = 1'b1; end
      OP_LW:         begin in_load = 1'b1;                  end
      OP_SB:         begin in_store = 1'b1; in_byte = 1'b1; end
      OP_SH:         begin in_store = 1'b1; in_half = 1'b1; end
      OP_SW:         begin in_store = 1'b1;                 end
      default:       ;
    endcase
    in_mem  = in_load | in_store;
    in_mis  = (in_half & ex_i[0]) | (in_mem & ~in_byte & ~in_half & (|ex_i[1:0]));
    if (in_byte) begin
      be_d    = 4'b0001 << ex_i[1:0];
      wdata_d = {4{rs2_data_i[7:0]}};
    end else if (in_half) begin
      be_d    = 4'b0011 << ex_i[1:0];
      wdata_d = {2{rs2_data_i[15:0]}};
    end else begin
      be_d    = 4'hF;
      wdata_d = rs2_data_i;
    end
    accept  = valid_i & ready_o;
    acc_go  = accept & in_mem & ~in_mis;
    acc_mis = accept & in_mem & in_mis;
  end

  // lane-select and extend the returned word for the captured load op
  always_comb begin
    byte_v = l1d_rdata_i[{addr_reg[1:0], 3'b000} +: 8];
    half_v = addr_reg[1] ? l1d_rdata_i[31:16] : l1d_rdata_i[15:0];
    case (op_reg)
      OP_LB:   load_fmt = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_fmt = {24'h0, byte_v};
      OP_LH:   load_fmt = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_fmt = {16'h0, half_v};
      default: load_fmt = l1d_rdata_i;
    endcase
  end

  // next-state logic: handshake progress, completion events and timeout
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    fin_store   = 1'b0;
    fin_load    = 1'b0;
    fin_tmo     = 1'b0;
    timeout_hit = (REQ_TIMEOUT != 0) && (cnt_reg >= CNT_LAST);
    case (state_reg)
      IDLE: begin
        if (acc_go) begin
          state_next = REQ;
          cnt_next   = '0;
        end
      end
      REQ: begin
        if (l1d_gnt_i) begin
          if (we_reg) begin
            fin_store  = 1'b1;
            state_next = IDLE;
          end else if (l1d_rvalid_i) begin
            fin_load   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_R;
            cnt_next   = cnt_reg + 1'b1;
          end
        end else if (timeout_hit) begin
          fin_tmo    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_R: begin
        if (l1d_rvalid_i) begin
          fin_load   = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          fin_tmo    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // state, captured request and the registered writeback bundle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      op_reg          <= '0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      be_reg          <= '0;
      we_reg          <= 1'b0;
      rd_reg          <= '0;
      rf_we_reg       <= 1'b0;
      sel_reg         <= '0;
      pc_reg          <= '0;
      wb_valid_o      <= 1'b0;
      wb_data_o       <= '0;
      mem_data_o      <= '0;
      rd_addr_o       <= '0;
      regfile_wr_en_o <= 1'b0;
      wb_mux_sel_o    <= '0;
      next_pc_o       <= '0;
      misaligned_o    <= 1'b0;
      bus_err_o       <= 1'b0;
      fault_addr_o    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wb_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      if (acc_go) begin
        op_reg    <= operation_i;
        addr_reg  <= ex_i;
        wdata_reg <= wdata_d;
        be_reg    <= be_d;
        we_reg    <= in_store & l1d_wr_en_i;
        rd_reg    <= rd_addr_i;
        rf_we_reg <= regfile_wr_en_i;
        sel_reg   <= wb_mux_sel_i;
        pc_reg    <= next_pc_i;
      end
      // non-memory ops and misaligned faults retire straight from the accept
      if (accept && (!in_mem || in_mis)) begin
        wb_valid_o      <= 1'b1;
        wb_data_o       <= ex_i;
        rd_addr_o       <= rd_addr_i;
        regfile_wr_en_o <= regfile_wr_en_i & ~acc_mis;
        wb_mux_sel_o    <= wb_mux_sel_i;
        next_pc_o       <= next_pc_i;
        if (acc_mis) begin
          misaligned_o <= 1'b1;
          fault_addr_o <= ex_i;
        end
      end
      if (fin_store || fin_load || fin_tmo) begin
        wb_valid_o      <= 1'b1;
        wb_data_o       <= fin_load ? load_fmt : addr_reg;
        rd_addr_o       <= rd_reg;
        regfile_wr_en_o <= rf_we_reg & ~fin_tmo;
        wb_mux_sel_o    <= sel_reg;
        next_pc_o       <= pc_reg;
      end
      if (fin_load) begin
        mem_data_o <= load_fmt;
      end
      if (fin_tmo) begin
        bus_err_o    <= 1'b1;
        fault_addr_o <= addr_reg;
      end
    end
  end

endmodule

// File: tb/tb_kamus_mem.sv
// Directed bench for kamus_mem with a short timeout (REQ_TIMEOUT=4).
module tb_kamus_mem;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_LB  = 6'h10;
  localparam logic [5:0] OP_LH  = 6'h11;
  localparam logic [5:0] OP_LW  = 6'h12;
  localparam logic [5:0] OP_LBU = 6'h13;
  localparam logic [5:0] OP_LHU = 6'h14;
  localparam logic [5:0] OP_SB  = 6'h18;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [5:0]  operation_i = '0;
  logic [31:0] ex_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        regfile_wr_en_i = 1'b0;
  logic [1:0]  wb_mux_sel_i = '0;
  logic        l1d_wr_en_i = 1'b0;
  logic [31:0] next_pc_i = '0;
  logic        l1d_req_o;
  logic        l1d_gnt_i = 1'b0;
  logic        l1d_we_o;
  logic [31:0] l1d_addr_o;
  logic [3:0]  l1d_be_o;
  logic [31:0] l1d_wdata_o;
  logic        l1d_rvalid_i = 1'b0;
  logic [31:0] l1d_rdata_i = '0;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [31:0] mem_data_o;
  logic [4:0]  rd_addr_o;
  logic        regfile_wr_en_o;
  logic [1:0]  wb_mux_sel_o;
  logic [31:0] next_pc_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic [31:0] fault_addr_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  kamus_mem #(.REQ_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .operation_i(operation_i), .ex_i(ex_i), .rs2_data_i(rs2_data_i),
    .rd_addr_i(rd_addr_i), .regfile_wr_en_i(regfile_wr_en_i),
    .wb_mux_sel_i(wb_mux_sel_i), .l1d_wr_en_i(l1d_wr_en_i), .next_pc_i(next_pc_i),
    .l1d_req_o(l1d_req_o), .l1d_gnt_i(l1d_gnt_i), .l1d_we_o(l1d_we_o),
    .l1d_addr_o(l1d_addr_o), .l1d_be_o(l1d_be_o), .l1d_wdata_o(l1d_wdata_o),
    .l1d_rvalid_i(l1d_rvalid_i), .l1d_rdata_i(l1d_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .mem_data_o(mem_data_o),
    .rd_addr_o(rd_addr_o), .regfile_wr_en_o(regfile_wr_en_o),
    .wb_mux_sel_o(wb_mux_sel_o), .next_pc_o(next_pc_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o), .fault_addr_o(fault_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // present one EX bundle for a single cycle (caller has checked ready_o)
  task automatic issue(input logic [5:0] op, input logic [31:0] ex, input logic [31:0] rs2,
                       input logic wr);
    valid_i         = 1'b1;
    operation_i     = op;
    ex_i            = ex;
    rs2_data_i      = rs2;
    rd_addr_i       = 5'd7;
    regfile_wr_en_i = ~wr;
    wb_mux_sel_i    = 2'd1;
    l1d_wr_en_i     = wr;
    next_pc_i       = 32'h104;
    step();
    valid_i = 1'b0;
  endtask

  // single-cycle load with gnt and rvalid together; returns formatted result
  task automatic quick_load(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [3:0] be_exp,
                            input logic [31:0] exp, input string tag);
    issue(op, addr, 32'h0, 1'b0);
    check({tag, "_req"}, {31'h0, l1d_req_o}, 32'h1);
    check({tag, "_be"}, {28'h0, l1d_be_o}, {28'h0, be_exp});
    l1d_gnt_i = 1'b1; l1d_rvalid_i = 1'b1; l1d_rdata_i = rdata;
    step();
    l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0;
    check({tag, "_wbv"}, {31'h0, wb_valid_o}, 32'h1);
    check({tag, "_data"}, wb_data_o, exp);
    check({tag, "_mem"}, mem_data_o, exp);
    $display("txn %s addr=0x%08h rdata=0x%08h -> wb_data=0x%08h", tag, addr, rdata, wb_data_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    step(); step();
    rst_ni = 1'b1;
    check("rst_wbv", {31'h0, wb_valid_o}, 32'h0);
    check("rst_req", {31'h0, l1d_req_o}, 32'h0);
    check("rst_wbdata", wb_data_o, 32'h0);
    check("rst_ready", {31'h0, ready_o}, 32'h1);
    $display("txn reset");

    // ADD passthrough
    issue(OP_ADD, 32'h1234, 32'h0, 1'b0);
    check("add_wbv", {31'h0, wb_valid_o}, 32'h1);
    check("add_data", wb_data_o, 32'h1234);
    check("add_rd", {27'h0, rd_addr_o}, 32'd7);
    check("add_pc", next_pc_o, 32'h104);
    check("add_req", {31'h0, l1d_req_o}, 32'h0);
    check("add_ready", {31'h0, ready_o}, 32'h1);
    step();
    check("add_wbv_pulse", {31'h0, wb_valid_o}, 32'h0);
    $display("txn ADD ex=0x1234 -> wb_data=0x%08h", wb_data_o);

    // SB addr=0x1003 with grant on the third request cycle
    issue(OP_SB, 32'h1003, 32'hAB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("sb_req", {31'h0, l1d_req_o}, 32'h1);
      check("sb_addr", l1d_addr_o, 32'h1000);
      check("sb_be", {28'h0, l1d_be_o}, 32'h8);
      check("sb_wdata", l1d_wdata_o, 32'hABABABAB);
      check("sb_ready", {31'h0, ready_o}, 32'h0);
      check("sb_wbv_early", {31'h0, wb_valid_o}, 32'h0);
      if (i == 2) l1d_gnt_i = 1'b1;
      step();
    end
    l1d_gnt_i = 1'b0;
    check("sb_req_done", {31'h0, l1d_req_o}, 32'h0);
    check("sb_wbv", {31'h0, wb_valid_o}, 32'h1);
    check("sb_ready_done", {31'h0, ready_o}, 32'h1);
    step();
    check("sb_wbv_pulse", {31'h0, wb_valid_o}, 32'h0);
    $display("txn SB addr=0x1003 data=0xAB");

    // loads with gnt and rvalid in the same cycle
    quick_load(OP_LB,  32'h2002, 32'h00800000, 4'b0100, 32'hFFFFFF80, "lb");
    quick_load(OP_LBU, 32'h2002, 32'h00800000, 4'b0100, 32'h00000080, "lbu");
    quick_load(OP_LH,  32'h2002, 32'h80010000, 4'b1100, 32'hFFFF8001, "lh");
    quick_load(OP_LHU, 32'h2000, 32'h80017FFE, 4'b0011, 32'h00007FFE, "lhu");

    // misaligned LH: no request, fault pulse
    issue(OP_LH, 32'h3001, 32'h0, 1'b0);
    check("mis_req", {31'h0, l1d_req_o}, 32'h0);
    check("mis_wbv", {31'h0, wb_valid_o}, 32'h1);
    check("mis_flag", {31'h0, misaligned_o}, 32'h1);
    check("mis_addr", fault_addr_o, 32'h3001);
    check("mis_rfwe", {31'h0, regfile_wr_en_o}, 32'h0);
    step();
    check("mis_flag_pulse", {31'h0, misaligned_o}, 32'h0);
    check("mis_req_after", {31'h0, l1d_req_o}, 32'h0);
    $display("txn LH addr=0x3001 misaligned");

    // aligned LW: gnt, then rvalid in WAIT_R, then an ADD accepted back-to-back
    issue(OP_LW, 32'h3004, 32'h0, 1'b0);
    check("lw_req", {31'h0, l1d_req_o}, 32'h1);
    check("lw_addr", l1d_addr_o, 32'h3004);
    check("lw_be", {28'h0, l1d_be_o}, 32'hF);
    check("lw_we", {31'h0, l1d_we_o}, 32'h0);
    l1d_gnt_i = 1'b1;
    step();
    l1d_gnt_i = 1'b0;
    check("lw_wait_req", {31'h0, l1d_req_o}, 32'h0);
    check("lw_wait_ready", {31'h0, ready_o}, 32'h0);
    l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'hDEADBEEF;
    step();
    l1d_rvalid_i = 1'b0;
    check("lw_wbv", {31'h0, wb_valid_o}, 32'h1);
    check("lw_data", wb_data_o, 32'hDEADBEEF);
    check("lw_rfwe", {31'h0, regfile_wr_en_o}, 32'h1);
    check("lw_ready", {31'h0, ready_o}, 32'h1);
    $display("txn LW addr=0x3004 -> 0x%08h", wb_data_o);
    issue(OP_ADD, 32'h77, 32'h0, 1'b0);
    check("b2b_wbv", {31'h0, wb_valid_o}, 32'h1);
    check("b2b_data", wb_data_o, 32'h77);
    $display("txn ADD back-to-back ex=0x77");

    // timeout: grant never arrives
    issue(OP_LW, 32'h4000, 32'h0, 1'b0);
    n = 0;
    while (l1d_req_o && n < 20) begin
      n++;
      step();
    end
    check("tmo_cycles", n, 32'd4);
    check("tmo_wbv", {31'h0, wb_valid_o}, 32'h1);
    check("tmo_buserr", {31'h0, bus_err_o}, 32'h1);
    check("tmo_rfwe", {31'h0, regfile_wr_en_o}, 32'h0);
    check("tmo_addr", fault_addr_o, 32'h4000);
    check("tmo_ready", {31'h0, ready_o}, 32'h1);
    step();
    check("tmo_pulse", {31'h0, bus_err_o}, 32'h0);
    $display("txn LW addr=0x4000 bus error after %0d cycles", n);

    // reset while waiting for read data, then a late rvalid
    issue(OP_LW, 32'h5000, 32'h0, 1'b0);
    l1d_gnt_i = 1'b1;
    step();
    l1d_gnt_i = 1'b0;
    check("rstmid_wait", {31'h0, ready_o}, 32'h0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("rstmid_req", {31'h0, l1d_req_o}, 32'h0);
    check("rstmid_wbv", {31'h0, wb_valid_o}, 32'h0);
    check("rstmid_data", wb_data_o, 32'h0);
    check("rstmid_ready", {31'h0, ready_o}, 32'h1);
    l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'h12345678;
    step();
    l1d_rvalid_i = 1'b0;
    check("late_rvalid_wbv", {31'h0, wb_valid_o}, 32'h0);
    check("late_rvalid_mem", mem_data_o, 32'h0);
    $display("txn LW addr=0x5000 aborted by reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
